// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the next-PC unit and its branch target buffer.
//   - addr_mode encodings for the resolve port
//   - 2-bit direction counter constants and saturating update helper
//   - instruction size used for sequential fetch and fall-through
package next_pc_unit_pkg;

    localparam logic ADDR_PC = 1'b0;   // target = resolve_pc + imm
    localparam logic ADDR_RD = 1'b1;   // target = (rs1d + imm) & ~1

    localparam logic [1:0] CTR_MIN   = 2'b00;
    localparam logic [1:0] CTR_INIT  = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_MAX   = 2'b11;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Saturating 2-bit counter step toward the observed direction.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
        end else begin
            res = (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/next_pc_unit_branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports:
//   clk, rstn            clock, async active-low reset
//   flush_i              clear every valid bit at the edge (wins over update)
//   lookup_pc_i          fetch PC to look up (combinational)
//   pred_taken_o         hit and counter MSB set
//   pred_target_o        stored target on hit, zero on miss
//   upd_valid_i          apply a resolved branch at the edge
//   upd_pc_i             PC of the resolving instruction
//   upd_taken_i          resolved direction
//   upd_target_i         resolved target address
module branch_target_buffer
    import next_pc_unit_pkg::*;
#(
    parameter int WordSize = 32,
    parameter int Entries  = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush_i,
    input  logic [WordSize-1:0] lookup_pc_i,
    output logic                pred_taken_o,
    output logic [WordSize-1:0] pred_target_o,
    input  logic                upd_valid_i,
    input  logic [WordSize-1:0] upd_pc_i,
    input  logic                upd_taken_i,
    input  logic [WordSize-1:0] upd_target_i
);

    localparam int IdxW = $clog2(Entries);
    localparam int TagW = WordSize - IdxW - 2;

    logic                valid_q  [Entries];
    logic [TagW-1:0]     tag_q    [Entries];
    logic [WordSize-1:0] target_q [Entries];
    logic [1:0]          ctr_q    [Entries];

    logic [IdxW-1:0] lk_idx_s;
    logic [TagW-1:0] lk_tag_s;
    logic            lk_hit_s;
    logic [IdxW-1:0] up_idx_s;
    logic [TagW-1:0] up_tag_s;
    logic            up_hit_s;
    logic            unused_bits_s;

    // Byte offset within the instruction never participates in index or tag.
    assign unused_bits_s = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    assign lk_idx_s = lookup_pc_i[IdxW+1:2];
    assign lk_tag_s = lookup_pc_i[WordSize-1:IdxW+2];
    assign up_idx_s = upd_pc_i[IdxW+1:2];
    assign up_tag_s = upd_pc_i[WordSize-1:IdxW+2];

    // Lookup and update hit detection against current (pre-update) contents.
    always_comb begin
        lk_hit_s      = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
        up_hit_s      = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
        pred_taken_o  = lk_hit_s && ctr_q[lk_idx_s][1];
        if (lk_hit_s) begin
            pred_target_o = target_q[lk_idx_s];
        end else begin
            pred_target_o = {WordSize{1'b0}};
        end
    end

    // Entry storage: flush clears valids only; otherwise apply resolved branch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Entries; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= {TagW{1'b0}};
                target_q[i] <= {WordSize{1'b0}};
                ctr_q[i]    <= CTR_INIT;
            end
        end else if (flush_i) begin
            for (int i = 0; i < Entries; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid_i) begin
            if (up_hit_s) begin
                ctr_q[up_idx_s] <= ctr_step(ctr_q[up_idx_s], upd_taken_i);
                if (upd_taken_i) begin
                    target_q[up_idx_s] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                valid_q[up_idx_s]  <= 1'b1;
                tag_q[up_idx_s]    <= up_tag_s;
                target_q[up_idx_s] <= upd_target_i;
                ctr_q[up_idx_s]    <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch-side next-PC generator.
// Holds the fetch PC, predicts the next fetch address from the BTB, resolves
// branches coming back from execute and redirects fetch on mispredict.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   stall                          hold fetch PC (a redirect still wins)
//   btb_flush                      invalidate all BTB entries at the edge
//   resolve_valid/resolve_pc/...   resolved branch from execute
//   pc                             registered fetch PC
//   pred_taken/pred_target         BTB prediction for pc
//   branch_addr/npc                computed target / correct next PC
//   redirect                       mispredict, fetch restarts at npc
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int                  WordSize    = 32,
    parameter int                  Entries     = 16,
    parameter logic [WordSize-1:0] ResetVector = {WordSize{1'b0}}
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stall,
    input  logic                btb_flush,
    input  logic                resolve_valid,
    input  logic [WordSize-1:0] resolve_pc,
    input  logic                addr_mode,
    input  logic                branch_taken,
    input  logic [WordSize-1:0] imm,
    input  logic [WordSize-1:0] rs1d,
    input  logic                pred_taken_in,
    input  logic [WordSize-1:0] pred_target_in,
    output logic [WordSize-1:0] pc,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_target,
    output logic [WordSize-1:0] branch_addr,
    output logic [WordSize-1:0] npc,
    output logic                redirect
);

    localparam logic [WordSize-1:0] Step = WordSize'(INSTR_BYTES);

    logic [WordSize-1:0] pc_q;
    logic [WordSize-1:0] pc_d;
    logic [WordSize-1:0] rd_sum_s;

    branch_target_buffer #(
        .WordSize (WordSize),
        .Entries  (Entries)
    ) u_btb (
        .clk           (clk),
        .rstn          (rstn),
        .flush_i       (btb_flush),
        .lookup_pc_i   (pc_q),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target),
        .upd_valid_i   (resolve_valid),
        .upd_pc_i      (resolve_pc),
        .upd_taken_i   (branch_taken),
        .upd_target_i  (branch_addr)
    );

    // Resolve-side target arithmetic and mispredict detection.
    always_comb begin
        rd_sum_s = rs1d + imm;
        if (addr_mode == ADDR_RD) begin
            branch_addr = {rd_sum_s[WordSize-1:1], 1'b0};
        end else begin
            branch_addr = resolve_pc + imm;
        end
        if (branch_taken) begin
            npc = branch_addr;
        end else begin
            npc = resolve_pc + Step;
        end
        // Wrong direction, or right "taken" direction with wrong target.
        redirect = resolve_valid &&
                   ((branch_taken != pred_taken_in) ||
                    (branch_taken && pred_taken_in && (branch_addr != pred_target_in)));
    end

    // Next fetch PC: redirect > stall > predicted taken > sequential.
    always_comb begin
        if (redirect) begin
            pc_d = npc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end else begin
            pc_d = pc_q + Step;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q <= ResetVector;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit (WordSize=32, Entries=16).
module tb_next_pc_unit;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        btb_flush;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        addr_mode;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic        pred_taken_in;
    logic [31:0] pred_target_in;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] branch_addr;
    logic [31:0] npc;
    logic        redirect;

    int checks   = 0;
    int failures = 0;

    next_pc_unit #(
        .WordSize    (32),
        .Entries     (16),
        .ResetVector (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .stall          (stall),
        .btb_flush      (btb_flush),
        .resolve_valid  (resolve_valid),
        .resolve_pc     (resolve_pc),
        .addr_mode      (addr_mode),
        .branch_taken   (branch_taken),
        .imm            (imm),
        .rs1d           (rs1d),
        .pred_taken_in  (pred_taken_in),
        .pred_target_in (pred_target_in),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .branch_addr    (branch_addr),
        .npc            (npc),
        .redirect       (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Step to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] rpc, input logic mode,
                         input logic tk, input logic [31:0] im, input logic [31:0] rs,
                         input logic pti, input logic [31:0] ptg);
        resolve_valid  = v;
        resolve_pc     = rpc;
        addr_mode      = mode;
        branch_taken   = tk;
        imm            = im;
        rs1d           = rs;
        pred_taken_in  = pti;
        pred_target_in = ptg;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // One resolve of the branch at 0x10 (target 0x50), predicted correctly so
    // no redirect; pc is stalled at 0x10 and the counter MSB is observed.
    task automatic ctr_step(input logic tk, input logic exp_pred, input string tag);
        drive(1'b1, 32'h10, 1'b0, tk, 32'h40, 32'h0, tk, 32'h50);
        #1;
        check({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
        tick();
        idle();
        #1;
        check({tag, "_pred"}, {31'd0, pred_taken}, {31'd0, exp_pred});
        check({tag, "_pc"}, pc, 32'h10);
    endtask

    initial begin
        rstn      = 1'b0;
        stall     = 1'b0;
        btb_flush = 1'b0;
        idle();
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);

        tick();
        rstn = 1'b1;
        tick();
        check("seq_pc4", pc, 32'h4);
        tick();
        check("seq_pc8", pc, 32'h8);
        check("seq_pred", {31'd0, pred_taken}, 32'd0);

        // Allocate 0x10 -> 0x50 through a mispredicted taken branch.
        drive(1'b1, 32'h10, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0);
        #1;
        check("alloc_baddr", branch_addr, 32'h50);
        check("alloc_npc", npc, 32'h50);
        check("alloc_redirect", {31'd0, redirect}, 32'd1);
        tick();
        idle();
        #1;
        check("alloc_pc", pc, 32'h50);
        // 0x50 shares index 4 with 0x10 but has a different tag.
        check("alias_pred", {31'd0, pred_taken}, 32'd0);
        check("alias_target", pred_target, 32'h0);

        // Not-taken branch at 0x0C predicted taken -> redirect to 0x10.
        drive(1'b1, 32'h0C, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h10C);
        #1;
        check("nt_npc", npc, 32'h10);
        check("nt_redirect", {31'd0, redirect}, 32'd1);
        tick();
        idle();
        #1;
        check("hit_pc", pc, 32'h10);
        check("hit_pred", {31'd0, pred_taken}, 32'd1);
        check("hit_target", pred_target, 32'h50);
        tick();
        check("pred_fetch_pc", pc, 32'h50);

        // Back to 0x10 with stall held; redirect overrides stall.
        stall = 1'b1;
        drive(1'b1, 32'h0C, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h10C);
        tick();
        idle();
        #1;
        check("back_pc", pc, 32'h10);

        // Same-cycle lookup still sees counter 2 before the update lands.
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h50);
        #1;
        check("same_cycle_pred", {31'd0, pred_taken}, 32'd1);
        check("nt_ok_npc", npc, 32'h14);
        ctr_step(1'b0, 1'b0, "ctr_2to1");
        ctr_step(1'b0, 1'b0, "ctr_1to0");
        ctr_step(1'b0, 1'b0, "ctr_sat0a");
        ctr_step(1'b0, 1'b0, "ctr_sat0b");
        ctr_step(1'b1, 1'b0, "ctr_0to1");
        ctr_step(1'b1, 1'b1, "ctr_1to2");
        ctr_step(1'b1, 1'b1, "ctr_2to3");
        ctr_step(1'b1, 1'b1, "ctr_sat3");
        ctr_step(1'b0, 1'b1, "ctr_3to2");
        ctr_step(1'b0, 1'b0, "ctr_2to1b");

        // JALR: (0x1001 + 2) & ~1 = 0x1002.
        drive(1'b1, 32'h200, 1'b1, 1'b1, 32'h2, 32'h1001, 1'b1, 32'h1002);
        #1;
        check("jalr_baddr", branch_addr, 32'h1002);
        check("jalr_ok_redirect", {31'd0, redirect}, 32'd0);
        pred_target_in = 32'h1000;
        #1;
        check("jalr_bad_redirect", {31'd0, redirect}, 32'd1);
        tick();
        check("jalr_pc", pc, 32'h1002);

        // Stall together with redirect to 0x200.
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 32'h0);
        #1;
        check("stall_redir_npc", npc, 32'h200);
        tick();
        idle();
        #1;
        check("stall_redir_pc", pc, 32'h200);
        tick();
        check("stall_hold1", pc, 32'h200);
        tick();
        check("stall_hold2", pc, 32'h200);
        tick();
        check("stall_hold3", pc, 32'h200);

        // Flush collides with a taken resolve at 0x20: nothing is allocated.
        btb_flush = 1'b1;
        drive(1'b1, 32'h20, 1'b0, 1'b1, 32'h8, 32'h0, 1'b1, 32'h28);
        #1;
        check("flush_redirect", {31'd0, redirect}, 32'd0);
        tick();
        btb_flush = 1'b0;
        drive(1'b1, 32'h1C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1C);
        tick();
        idle();
        #1;
        check("flush_pc", pc, 32'h20);
        check("flush_pred", {31'd0, pred_taken}, 32'd0);
        check("flush_target", pred_target, 32'h0);
        stall = 1'b0;
        tick();
        check("flush_seq_pc", pc, 32'h24);

        // Modular wrap, resolve_valid low keeps redirect low.
        drive(1'b0, 32'hFFFF_FFF0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0);
        #1;
        check("wrap_baddr", branch_addr, 32'h10);
        check("novalid_redirect", {31'd0, redirect}, 32'd0);

        // Reset mid-run with a resolve in flight.
        drive(1'b1, 32'h300, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0);
        rstn = 1'b0;
        #1;
        check("midrst_pc", pc, 32'h0);
        tick();
        idle();
        rstn = 1'b1;
        tick();
        check("midrst_seq_pc", pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
Fetch-side next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It holds the fetch PC register and predicts next fetch address from the BTB. It also resolves branches from execute, supporting PC-relative and register-relative (JALR-style) targets, and redirects fetch on mispredict. Sits between fetch and execute; execute supplies the resolved branch, fetch consumes pc and the prediction.

Parameters:
WordSize, 32, data/address width in bits
Entries, 16, BTB entries; power of two, >= 2
ResetVector, 0, fetch PC after reset

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, asynchronous, active-low
stall  input  1  hold fetch PC this cycle
btb_flush  input  1  synchronously invalidate all BTB entries
resolve_valid  input  1  execute presents a resolved branch/jump
resolve_pc  input  WordSize  PC of resolving instruction
addr_mode  input  1  0 = PC-relative (pc+imm), 1 = register-relative (rs1d+imm)
branch_taken  input  1  actual direction
imm  input  WordSize  sign-extended immediate
rs1d  input  WordSize  rs1 data
pred_taken_in  input  1  prediction made at fetch for resolving instruction
pred_target_in  input  WordSize  predicted target carried down pipe
pc  output  WordSize  current fetch PC (registered)
pred_taken  output  1  BTB predicts taken for pc
pred_target  output  WordSize  BTB target for pc (0 on miss)
branch_addr  output  WordSize  computed target of resolving instruction
npc  output  WordSize  architecturally correct next PC of resolving instruction
redirect  output  1  mispredict; fetch restarts at npc next cycle

Behaviour:
- Reset (rstn low, async): pc = ResetVector; all BTB valid = 0, targets = 0, counters = 2'b01. Combinational outputs follow from reset state: pred_taken = 0, pred_target = 0, redirect = 0.
- Index = pc[log2(Entries)+1:2]; tag = remaining upper bits. Bits [1:0] ignored.
- Lookup (combinational on pc): hit = valid[idx] & tag match. pred_taken = hit & ctr[idx][1]. pred_target = hit ? target[idx] : 0.
- Target calculation (combinational): addr_mode 0: branch_addr = resolve_pc + imm. addr_mode 1: branch_addr = (rs1d + imm) with bit 0 forced 0. All sums modulo 2^WordSize, wrap silently.
- npc = branch_taken ? branch_addr : resolve_pc + 4.
- redirect = resolve_valid & ((branch_taken != pred_taken_in) | (branch_taken & pred_taken_in & branch_addr != pred_target_in)). It is 0 when resolve_valid = 0.
- PC register update, priority order:
  - redirect: pc <= npc. Overrides stall.
  - else stall: pc holds.
  - else pred_taken: pc <= pred_target.
  - else: pc <= pc + 4.
- Redirect latency: 1 cycle (pc == npc on the edge after redirect is asserted).
- BTB update on clock edge when resolve_valid, using resolve_pc index/tag:
  - Taken and hit: target <= branch_addr; counter increments, saturating at 3.
  - Taken and miss: allocate. valid <= 1, tag written, target <= branch_addr, counter <= 2'b10.
  - Not taken and hit: counter decrements, saturating at 0. Entry stays valid.
  - Not taken and miss: no change.
- Updates are independent of stall.
- Same-cycle lookup and update to one index: lookup sees pre-update contents; the update is visible the next cycle.
- btb_flush: valid bits cleared at the edge. If resolve_valid is also high that cycle, the flush wins and no allocation occurs. Counters and targets are left untouched.
- Reset mid-operation: immediate return to reset state. In-flight resolve is discarded.

Decomposition:
- Shared package: addr_mode encoding (ADDR_PC = 0, ADDR_RD = 1); counter constants (CTR_INIT = 2'b01, CTR_ALLOC = 2'b10, CTR_MAX = 2'b11); INSTR_BYTES = 4.
- One sub-module, branch_target_buffer: valid/tag/target/counter arrays, lookup port, and update port with flush. next_pc_unit keeps the pc register, target arithmetic and mispredict logic.

Test Plan:
- Reset: rstn low with pc mid-run -> pc = 0 immediately. After release with no resolves, pc steps 0, 4, 8; pred_taken = 0.
- Allocate then predict: resolve_pc = 0x10, mode 0, imm = 0x40, taken, pred_taken_in = 0 -> branch_addr = 0x50, npc = 0x50, redirect = 1, pc = 0x50 next cycle. Later fetch of 0x10 -> pred_taken = 1, pred_target = 0x50, next pc = 0x50.
- Counter saturation: at entry 0x10, resolve not-taken twice -> counter goes 2→1→0, pred_taken = 0 for 0x10. Two more not-taken keep counter at 0. Three taken -> counter saturates at 3.
- JALR alignment: mode 1, rs1d = 0x1001, imm = 0x2, taken, pred_target_in = 0x1002 -> branch_addr = 0x1002, redirect = 0. Same case with pred_target_in = 0x1000 -> redirect = 1.
- Stall vs redirect: stall = 1 and redirect = 1 with npc = 0x200 -> pc = 0x200. Stall alone for 3 cycles -> pc held.
- Flush collision and aliasing: btb_flush with a taken resolve in the same cycle -> no entry allocated, next lookup misses. With Entries = 16, addresses 0x10 and 0x50 share an index; the tag mismatch on 0x50 gives a miss.
